// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs, FSM states,
// datapath select codes and instruction classes. No logic, no latency, no backpressure.
package mc_ctrl_pkg;

  localparam int STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_IMM_EX   = 4'd8,
    S_IMM_WB   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [1:0] IMM_ZERO   = 2'd0;
  localparam logic [1:0] IMM_SIGN   = 2'd1;
  localparam logic [1:0] IMM_HI     = 2'd2;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_SUB    = 2'd1;
  localparam logic [1:0] ALU_OR     = 2'd2;

  localparam logic [1:0] PC_ALU     = 2'd0;
  localparam logic [1:0] PC_ALUOUT  = 2'd1;
  localparam logic [1:0] PC_JTARGET = 2'd2;
  localparam logic [1:0] PC_RS      = 2'd3;

  localparam logic [1:0] RD_RT      = 2'd0;
  localparam logic [1:0] RD_RD      = 2'd1;
  localparam logic [1:0] RD_RA      = 2'd2;

  localparam logic [1:0] M2R_ALU    = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_ADDU    = 4'd1,
    CLS_SUBU    = 4'd2,
    CLS_JR      = 4'd3,
    CLS_ORI     = 4'd4,
    CLS_LUI     = 4'd5,
    CLS_LW      = 4'd6,
    CLS_SW      = 4'd7,
    CLS_BEQ     = 4'd8,
    CLS_J       = 4'd9,
    CLS_JAL     = 4'd10
  } iclass_t;

endpackage

// File: rtl/instr_class_dec.sv
// Maps opcode/funct to an instruction class; purely combinational, zero latency.
// No handshake: the class follows the IR contents directly.
import mc_ctrl_pkg::*;

module instr_class_dec (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic       illegal
);

  always_comb begin
    iclass = CLS_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: iclass = CLS_ADDU;
          FN_SUBU: iclass = CLS_SUBU;
          FN_JR:   iclass = CLS_JR;
          default: iclass = CLS_ILLEGAL;
        endcase
      end
      OP_ORI:  iclass = CLS_ORI;
      OP_LUI:  iclass = CLS_LUI;
      OP_LW:   iclass = CLS_LW;
      OP_SW:   iclass = CLS_SW;
      OP_BEQ:  iclass = CLS_BEQ;
      OP_J:    iclass = CLS_J;
      OP_JAL:  iclass = CLS_JAL;
      default: iclass = CLS_ILLEGAL;
    endcase
  end

  assign illegal = (iclass == CLS_ILLEGAL);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller: Moore decode of state + IR, 3-5 cycles per instruction.
// Backpressure: FETCH, MEMRD and MEMWR hold while MemRdy is low, one extra cycle per stall.
import mc_ctrl_pkg::*;

module mc_ctrl_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        MemRdy,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSrc,
  output logic [1:0]  ImmSrc,
  output logic        InstrDone,
  output logic        IllegalInstr
);

  state_t  state, state_nxt;
  iclass_t iclass;
  logic    dec_illegal;
  logic    unused_bits;

  // Only opcode/funct steer control; the FSM relies on the class alone.
  assign unused_bits = ^{instr[25:6], dec_illegal};

  instr_class_dec u_dec (
    .opcode  (instr[31:26]),
    .funct   (instr[5:0]),
    .iclass  (iclass),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    PCWrite      = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    RegDst       = RD_RT;
    MemtoReg     = M2R_ALU;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_RT;
    ALUOp        = ALU_ADD;
    PCSrc        = PC_ALU;
    ImmSrc       = IMM_SIGN;
    InstrDone    = 1'b0;
    IllegalInstr = 1'b0;

    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = MemRdy;
        PCWrite = MemRdy;
        state_nxt = MemRdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while the class resolves.
        ALUSrcB = SRCB_IMMSH;
        case (iclass)
          CLS_LW, CLS_SW:        state_nxt = S_MEMADR;
          CLS_ADDU, CLS_SUBU:    state_nxt = S_RTYPE_EX;
          CLS_ORI, CLS_LUI:      state_nxt = S_IMM_EX;
          CLS_BEQ:               state_nxt = S_BRANCH;
          CLS_J, CLS_JAL, CLS_JR: state_nxt = S_JUMP;
          default: begin
            IllegalInstr = 1'b1;
            state_nxt    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = (iclass == CLS_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead   = 1'b1;
        IorD      = 1'b1;
        state_nxt = MemRdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = M2R_MDR;
        InstrDone = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        IorD      = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = MemRdy;
        state_nxt = MemRdy ? S_FETCH : S_MEMWR;
      end
      S_RTYPE_EX: begin
        ALUSrcA   = 1'b1;
        ALUOp     = (iclass == CLS_SUBU) ? ALU_SUB : ALU_ADD;
        state_nxt = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        RegWrite  = 1'b1;
        RegDst    = RD_RD;
        InstrDone = 1'b1;
        state_nxt = S_FETCH;
      end
      S_IMM_EX: begin
        // lui ORs the shifted immediate with rs, which the encoding fixes to $0.
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        ALUOp     = ALU_OR;
        ImmSrc    = (iclass == CLS_LUI) ? IMM_HI : IMM_ZERO;
        state_nxt = S_IMM_WB;
      end
      S_IMM_WB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUOp     = ALU_SUB;
        PCSrc     = PC_ALUOUT;
        PCWrite   = Zero;
        InstrDone = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        PCWrite   = 1'b1;
        InstrDone = 1'b1;
        PCSrc     = (iclass == CLS_JR) ? PC_RS : PC_JTARGET;
        if (iclass == CLS_JAL) begin
          // PC was already advanced in FETCH, so it is the link value.
          RegWrite = 1'b1;
          RegDst   = RD_RA;
          MemtoReg = M2R_PC;
        end
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase

    if (reset) begin
      PCWrite      = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      InstrDone    = 1'b0;
      IllegalInstr = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed scenarios plus randomized instruction streams
// checked cycle-by-cycle against a per-instruction trace model.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        Zero = 1'b0;
  logic        MemRdy = 1'b0;
  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, ALUOp, PCSrc, ImmSrc;
  logic        ALUSrcA, InstrDone, IllegalInstr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .instr(instr), .Zero(Zero), .MemRdy(MemRdy),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .ImmSrc(ImmSrc), .InstrDone(InstrDone), .IllegalInstr(IllegalInstr)
  );

  typedef struct packed {
    logic       pcwrite, iord, memread, memwrite, irwrite, regwrite;
    logic [1:0] regdst, memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb, aluop, pcsrc, immsrc;
    logic       instrdone, illegal;
  } out_t;

  out_t obs_q[$];
  out_t exp_q[$];

  function automatic out_t sample();
    out_t o;
    o.pcwrite = PCWrite;   o.iord = IorD;         o.memread = MemRead;
    o.memwrite = MemWrite; o.irwrite = IRWrite;   o.regwrite = RegWrite;
    o.regdst = RegDst;     o.memtoreg = MemtoReg; o.alusrca = ALUSrcA;
    o.alusrcb = ALUSrcB;   o.aluop = ALUOp;       o.pcsrc = PCSrc;
    o.immsrc = ImmSrc;     o.instrdone = InstrDone; o.illegal = IllegalInstr;
    return o;
  endfunction

  function automatic out_t blank();
    out_t c = '0;
    c.immsrc = 2'd1;
    return c;
  endfunction

  function automatic string kind_of(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00) begin
      if (fn == 6'h21) return "addu";
      if (fn == 6'h23) return "subu";
      if (fn == 6'h08) return "jr";
      return "bad";
    end
    case (op)
      6'h0d: return "ori";
      6'h0f: return "lui";
      6'h23: return "lw";
      6'h2b: return "sw";
      6'h04: return "beq";
      6'h02: return "j";
      6'h03: return "jal";
      default: return "bad";
    endcase
  endfunction

  // Expected per-cycle outputs of one instruction, given MemRdy per cycle (bit k = cycle k).
  task automatic build_exp(input logic [31:0] ins, input logic [63:0] rdy, input logic z);
    out_t  c;
    int    k;
    string kd;
    kd = kind_of(ins);
    exp_q.delete();
    k = 0;
    while (1) begin
      c = blank(); c.memread = 1'b1; c.alusrcb = 2'd1;
      c.irwrite = rdy[k]; c.pcwrite = rdy[k];
      exp_q.push_back(c); k++;
      if (rdy[k-1] || k >= 60) break;
    end
    c = blank(); c.alusrcb = 2'd3;
    if (kd == "bad") c.illegal = 1'b1;
    exp_q.push_back(c); k++;
    if (kd == "bad") return;
    if (kd == "lw" || kd == "sw") begin
      c = blank(); c.alusrca = 1'b1; c.alusrcb = 2'd2;
      exp_q.push_back(c); k++;
      while (1) begin
        c = blank(); c.iord = 1'b1;
        if (kd == "lw") c.memread = 1'b1;
        else begin c.memwrite = 1'b1; c.instrdone = rdy[k]; end
        exp_q.push_back(c); k++;
        if (rdy[k-1] || k >= 60) break;
      end
      if (kd == "lw") begin
        c = blank(); c.regwrite = 1'b1; c.memtoreg = 2'd1; c.instrdone = 1'b1;
        exp_q.push_back(c);
      end
    end else if (kd == "addu" || kd == "subu") begin
      c = blank(); c.alusrca = 1'b1; c.aluop = (kd == "subu") ? 2'd1 : 2'd0;
      exp_q.push_back(c);
      c = blank(); c.regwrite = 1'b1; c.regdst = 2'd1; c.instrdone = 1'b1;
      exp_q.push_back(c);
    end else if (kd == "ori" || kd == "lui") begin
      c = blank(); c.alusrca = 1'b1; c.alusrcb = 2'd2; c.aluop = 2'd2;
      c.immsrc = (kd == "ori") ? 2'd0 : 2'd2;
      exp_q.push_back(c);
      c = blank(); c.regwrite = 1'b1; c.instrdone = 1'b1;
      exp_q.push_back(c);
    end else if (kd == "beq") begin
      c = blank(); c.alusrca = 1'b1; c.aluop = 2'd1; c.pcsrc = 2'd1;
      c.pcwrite = z; c.instrdone = 1'b1;
      exp_q.push_back(c);
    end else begin
      c = blank(); c.pcwrite = 1'b1; c.instrdone = 1'b1;
      c.pcsrc = (kd == "jr") ? 2'd3 : 2'd2;
      if (kd == "jal") begin c.regwrite = 1'b1; c.regdst = 2'd2; c.memtoreg = 2'd2; end
      exp_q.push_back(c);
    end
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns the same way.
  task automatic exec(input logic [31:0] ins, input logic [63:0] rdy, input logic z, output bit tmo);
    out_t o;
    obs_q.delete();
    instr = ins; Zero = z; tmo = 1'b1;
    for (int k = 0; k < 64; k++) begin
      MemRdy = rdy[k];
      #1; o = sample(); obs_q.push_back(o);
      @(posedge clk); #1;
      if (o.instrdone || o.illegal) begin tmo = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    out_t o, e;
    reset = 1'b1; MemRdy = 1'b1; instr = 32'h00221821;
    repeat (2) @(posedge clk);
    #2; o = sample();
    e = blank(); e.alusrcb = 2'd1;
    tests++;
    if (o !== e) begin fails++; $display("FAIL reset_strobes: got %h want %h", o, e); end
    reset = 1'b0; #1; o = sample();
    e = blank(); e.alusrcb = 2'd1; e.memread = 1'b1; e.irwrite = 1'b1; e.pcwrite = 1'b1;
    tests++;
    if (o !== e) begin fails++; $display("FAIL reset_fetch: got %h want %h", o, e); end
    MemRdy = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    logic [31:0] tbl[2] = '{32'h00221821, 32'h00221823};
    bit tmo;
    foreach (tbl[i]) begin
      exec(tbl[i], '1, 1'b0, tmo); build_exp(tbl[i], '1, 1'b0);
      tests++;
      if (tmo || obs_q.size() != 4) begin fails++; $display("FAIL rtype_len: got %0d cycles want 4 (timeout %0b)", obs_q.size(), tmo); end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
        tests++;
        if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL rtype %h cyc%0d: got %h want %h", tbl[i], k, obs_q[k], exp_q[k]); end
      end
    end
    exec(32'h00221821, '1, 1'b0, tmo);
    tests++;
    if (obs_q.size() < 4 || obs_q[2].aluop !== 2'd0 || obs_q[3].regwrite !== 1'b1 || obs_q[3].regdst !== 2'd1 ||
        obs_q[3].memtoreg !== 2'd0 || obs_q[3].instrdone !== 1'b1)
      begin fails++; $display("FAIL addu_wb: got size %0d, cycle outputs do not match add/writeback", obs_q.size()); end
  endtask

  task automatic test_imm();
    logic [31:0] tbl[2] = '{32'h3401f000, 32'h3c01f000};
    logic [1:0]  imm[2] = '{2'd0, 2'd2};
    bit tmo;
    foreach (tbl[i]) begin
      exec(tbl[i], '1, 1'b0, tmo); build_exp(tbl[i], '1, 1'b0);
      tests++;
      if (tmo || obs_q.size() != exp_q.size()) begin fails++; $display("FAIL imm_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
        tests++;
        if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL imm %h cyc%0d: got %h want %h", tbl[i], k, obs_q[k], exp_q[k]); end
      end
      tests++;
      if (obs_q.size() < 4 || obs_q[2].immsrc !== imm[i] || obs_q[2].aluop !== 2'd2 || obs_q[3].regwrite !== 1'b1 || obs_q[3].regdst !== 2'd0)
        begin fails++; $display("FAIL imm_spot %h: got immsrc %0d want %0d", tbl[i], obs_q.size() > 2 ? obs_q[2].immsrc : 2'bx, imm[i]); end
    end
  endtask

  task automatic test_mem_stall();
    logic [63:0] lw_rdy = 64'hFFFF_FFFF_FFFF_FFE7;
    logic [63:0] sw_rdy = 64'hFFFF_FFFF_FFFF_FFDC;
    bit tmo;
    int held;
    exec(32'h8c220004, lw_rdy, 1'b0, tmo); build_exp(32'h8c220004, lw_rdy, 1'b0);
    held = 0;
    foreach (obs_q[k]) if (obs_q[k].memread && obs_q[k].iord) held++;
    tests++;
    if (tmo || obs_q.size() != 7 || held != 3 || obs_q[6].regwrite !== 1'b1 || obs_q[6].memtoreg !== 2'd1)
      begin fails++; $display("FAIL lw_stall: got %0d cycles, %0d read-hold cycles; want 7 and 3", obs_q.size(), held); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL lw cyc%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    exec(32'hac220004, sw_rdy, 1'b0, tmo); build_exp(32'hac220004, sw_rdy, 1'b0);
    tests++;
    if (tmo || obs_q.size() != 7) begin fails++; $display("FAIL sw_stall_len: got %0d want 7", obs_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests++;
      if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL sw cyc%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_branch_jump();
    logic [31:0] tbl[5] = '{32'h10220003, 32'h10220003, 32'h0c000010, 32'h08000010, 32'h03e00008};
    logic        zz[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bit tmo;
    foreach (tbl[i]) begin
      exec(tbl[i], '1, zz[i], tmo); build_exp(tbl[i], '1, zz[i]);
      tests++;
      if (tmo || obs_q.size() != 3) begin fails++; $display("FAIL bj_len %h: got %0d want 3", tbl[i], obs_q.size()); end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
        tests++;
        if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL bj %h z%0b cyc%0d: got %h want %h", tbl[i], zz[i], k, obs_q[k], exp_q[k]); end
      end
    end
    exec(32'h0c000010, '1, 1'b0, tmo);
    tests++;
    if (obs_q.size() < 3 || obs_q[2].pcwrite !== 1'b1 || obs_q[2].pcsrc !== 2'd2 || obs_q[2].regwrite !== 1'b1 ||
        obs_q[2].regdst !== 2'd2 || obs_q[2].memtoreg !== 2'd2)
      begin fails++; $display("FAIL jal_spot: got %h want pcwrite/pcsrc2/link to $31", obs_q.size() > 2 ? obs_q[2] : out_t'('x)); end
  endtask

  task automatic test_reset_in_memwr();
    out_t o, e;
    instr = 32'hac220004; Zero = 1'b0; MemRdy = 1'b1;
    repeat (3) begin #1; @(posedge clk); #1; end
    MemRdy = 1'b0; #1; o = sample();
    tests++;
    if (o.memwrite !== 1'b1 || o.iord !== 1'b1) begin fails++; $display("FAIL memwr_stall: got memwrite %b iord %b want 1 1", o.memwrite, o.iord); end
    reset = 1'b1; #1; o = sample();
    e = blank(); e.iord = 1'b1;
    tests++;
    if (o !== e) begin fails++; $display("FAIL memwr_reset: got %h want %h", o, e); end
    @(posedge clk); #1; reset = 1'b0; #1; o = sample();
    e = blank(); e.memread = 1'b1; e.alusrcb = 2'd1;
    tests++;
    if (o !== e) begin fails++; $display("FAIL memwr_reset_next: got %h want %h", o, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    logic [31:0] tbl[3] = '{32'hfc000000, 32'h00221820, 32'h20010005};
    bit tmo;
    foreach (tbl[i]) begin
      exec(tbl[i], '1, 1'b0, tmo); build_exp(tbl[i], '1, 1'b0);
      tests++;
      if (tmo || obs_q.size() != 2 || obs_q[1] !== exp_q[1])
        begin fails++; $display("FAIL illegal %h: got %0d cycles, decode %h want 2, %h", tbl[i], obs_q.size(), obs_q.size() > 1 ? obs_q[1] : out_t'('x), exp_q[1]); end
    end
    exec(32'h00221821, '1, 1'b0, tmo);
    tests++;
    if (tmo || obs_q.size() != 4) begin fails++; $display("FAIL after_illegal: got %0d cycles want 4", obs_q.size()); end
  endtask

  task automatic test_random();
    logic [5:0]  ops[10] = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03};
    logic [5:0]  fns[3]  = '{6'h21, 6'h23, 6'h08};
    logic [31:0] ins;
    logic [63:0] rdy;
    logic        z;
    bit          tmo;
    int          sel;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 11);
      ins = $urandom;
      if (sel < 3)       ins = {6'h00, ins[25:6], fns[sel]};
      else if (sel < 10) ins = {ops[sel], ins[25:0]};
      else if (sel == 10) ins = {6'h00, ins[25:6], 6'h20};
      else               ins = {6'h3f, ins[25:0]};
      rdy = {32'hFFFF_FFFF, ($urandom | $urandom)};
      z = 1'($urandom);
      exec(ins, rdy, z, tmo); build_exp(ins, rdy, z);
      tests++;
      if (tmo || obs_q.size() != exp_q.size())
        begin fails++; $display("FAIL rand_len %h: got %0d want %0d (timeout %0b)", ins, obs_q.size(), exp_q.size(), tmo); end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
        tests++;
        if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL rand %h cyc%0d: got %h want %h", ins, k, obs_q[k], exp_q[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_imm();
    test_mem_stall();
    test_branch_jump();
    test_reset_in_memwr();
    test_illegal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle MIPS main controller. Sequences the shared datapath (PC, unified memory, IR, register file, ALU, EXT) through fetch/decode/execute/writeback, one instruction at a time. Drives the EXT ImmSrc select per state and opcode. Also drives every mux select and write strobe, and stalls on a memory-ready handshake.

Parameters:
STATE_W, 4, state register width (12 states used)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; state -> FETCH
instr  input  32  current IR contents (opcode [31:26], funct [5:0])
Zero  input  1  ALU equality flag
MemRdy  input  1  memory completes access this cycle
PCWrite  output  1  PC load strobe
IorD  output  1  memory address: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write strobe
IRWrite  output  1  IR load strobe
RegWrite  output  1  register file write strobe
RegDst  output  2  0 = rt, 1 = rd, 2 = $31
MemtoReg  output  2  0 = ALUOut, 1 = MDR, 2 = PC
ALUSrcA  output  1  0 = PC, 1 = rs
ALUSrcB  output  2  0 = rt, 1 = const 4, 2 = imm, 3 = imm<<2
ALUOp  output  2  0 = ADD, 1 = SUB, 2 = OR
PCSrc  output  2  0 = ALU result, 1 = ALUOut, 2 = {PC[31:28],instr[25:0],2'b00}, 3 = rs
ImmSrc  output  2  EXT mode: 0 = zero-ext imm16, 1 = sign-ext imm16, 2 = imm16<<16
InstrDone  output  1  pulse on final cycle of each instruction
IllegalInstr  output  1  pulse in DECODE on an unsupported encoding

Behaviour:
- Supported: addu/subu/jr (op 0, funct 0x21/0x23/0x08), ori 0x0d, lui 0x0f, lw 0x23, sw 0x2b, beq 0x04, j 0x02, jal 0x03.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, IMM_EX, IMM_WB, BRANCH, JUMP.
- Outputs are a Moore decode of state plus latched instr. All outputs not listed for a state are 0.
- While reset = 1, all strobes are forced to 0 (PCWrite, MemRead, MemWrite, IRWrite, RegWrite, InstrDone, IllegalInstr); state <= FETCH at the edge.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSrc=0. IRWrite and PCWrite = MemRdy. Stay in FETCH while MemRdy=0, else go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=ADD, ImmSrc=1 (branch target precompute). Next state by class:
  - lw/sw -> MEMADR
  - R-type (addu/subu) -> RTYPE_EX
  - ori/lui -> IMM_EX
  - beq -> BRANCH
  - j/jal/jr -> JUMP
  - unsupported -> FETCH with IllegalInstr=1 and no writes.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ImmSrc=1, ADD. Go to MEMRD (lw) or MEMWR (sw).
- MEMRD: MemRead=1, IorD=1. Hold until MemRdy, then go to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1, InstrDone=1. Go to FETCH.
- MEMWR: IorD=1, MemWrite=1. Hold until MemRdy; InstrDone=MemRdy. Go to FETCH on MemRdy. MemWrite stays high through the whole stall.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=0, ALUOp = ADD (addu) or SUB (subu). Go to RTYPE_WB.
- RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0, InstrDone=1. Go to FETCH.
- IMM_EX: ALUSrcA=1, ALUSrcB=2.
  - ori: ImmSrc=0, ALUOp=OR.
  - lui: ImmSrc=2, ALUOp=OR, ALUSrcA=1 with rs=$0 by encoding.
  - Go to IMM_WB.
- IMM_WB: RegWrite=1, RegDst=0, MemtoReg=0, InstrDone=1. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCSrc=1, PCWrite=Zero, InstrDone=1. Go to FETCH.
- JUMP: PCWrite=1, InstrDone=1.
  - j/jal: PCSrc=2.
  - jr: PCSrc=3.
  - jal additionally: RegWrite=1, RegDst=2, MemtoReg=2 (PC already holds PC+4).
- Latency without stalls, in cycles: R 4, ori/lui 4, lw 5, sw 4, beq 3, jumps 3. Each MemRdy=0 cycle adds one.
- ImmSrc outside DECODE, MEMADR and IMM_EX = 1.
- Invariants:
  - Never MemRead and MemWrite in the same cycle.
  - IRWrite only in FETCH.
  - Unreachable state encodings go to FETCH.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode and funct constants
  - state enum
  - ImmSrc, ALUOp, PCSrc, RegDst and MemtoReg code constants
  - instruction-class enum
- Sub-module instr_class_dec: combinational mapping from opcode/funct to class plus illegal flag. The FSM consumes only the class.

Test Plan:
- addu 0x00221821, MemRdy=1 -> states FETCH, DECODE, RTYPE_EX, RTYPE_WB. Cycle 4 has RegWrite=1, RegDst=1, MemtoReg=0, InstrDone=1. RTYPE_EX has ALUOp=ADD.
- ori 0x3401f000 -> IMM_EX has ImmSrc=0, ALUOp=OR. lui 0x3c01f000 -> IMM_EX has ImmSrc=2. Both show RegWrite=1, RegDst=0 in cycle 4.
- lw 0x8c220004, MemRdy=0 for two MEMRD cycles -> MemRead=1, IorD=1 held for 3 cycles. MEMWB (RegWrite=1, MemtoReg=1) lands in cycle 7.
- beq 0x10220003 -> with Zero=1: BRANCH has PCWrite=1, PCSrc=1. With Zero=0: PCWrite=0. Both back in FETCH at cycle 4.
- jal 0x0c000010 -> JUMP has PCWrite=1, PCSrc=2, RegWrite=1, RegDst=2, MemtoReg=2.
- Reset asserted in MEMWR with MemRdy=0 -> MemWrite=0 that cycle, FETCH next. Opcode 0x3f -> IllegalInstr=1 in DECODE, no writes, FETCH next.
